polmem_reader: RTL and testbench

Read-side counterpart of the vector-multiplication controller's PolMem write path. Once the controller has written the 64-word accumulated result polynomial into PolMem and raised its done level, this block reads PolMem in address order and streams the words out on a valid/ready interface. It also masks each coefficient lane to the coefficient width. It sits between PolMem's read port and the downstream packer/hash unit, and it absorbs the one-cycle BRAM read latency with a 2-entry skid buffer so that backpressure never loses or duplicates a word.

---
 rtl/polmem_reader.sv | 131 +++++++++++++
 tb/tb_polmem_reader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/polmem_reader.sv
// Streams the 64-word PolMem result polynomial out on a valid/ready port,
// masking every 16-bit lane to COEF_W bits; a 2-entry skid FIFO absorbs the BRAM read latency.
module polmem_reader #(
    parameter int WORDS  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 64,
    parameter int COEF_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam int                CNT_W     = ADDR_W + 1;
    localparam int                LANES     = DATA_W / 16;
    localparam logic [15:0]       LANE_MASK = 16'((1 << COEF_W) - 1);
    localparam logic [DATA_W-1:0] WORD_MASK = {LANES{LANE_MASK}};
    localparam logic [CNT_W-1:0]  WORDS_C   = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0]  LAST_C    = CNT_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  pop_count;
    logic              inflight;
    logic [1:0]        fifo_count;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [DATA_W-1:0] fifo_mem [2];
    logic [2:0]        pending;
    logic              pop;
    logic              can_issue;
    logic              launch;

    function automatic logic [DATA_W-1:0] mask_coef(input logic [DATA_W-1:0] word);
        return word & WORD_MASK;
    endfunction

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    assign out_last  = out_valid && (pop_count == LAST_C);
    assign pop       = out_valid && out_ready;
    assign launch    = start && ((state == IDLE) || (state == DONE));

    // A slot frees up in the same cycle the head is popped, so the pop is credited here.
    assign pending   = {1'b0, fifo_count} + {2'b00, inflight};
    assign can_issue = (issued < WORDS_C) && (pending < (3'd2 + {2'b00, pop}));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = READ;
            READ:    if (out_last && out_ready) state_next = DONE;
            DONE:    if (start) state_next = READ;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        mem_ren = 1'b0;
        case (state)
            READ: begin
                busy    = 1'b1;
                mem_ren = can_issue;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || launch) begin
            issued      <= '0;
            pop_count   <= '0;
            inflight    <= 1'b0;
            fifo_count  <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            mem_address <= '0;
        end else begin
            inflight <= mem_ren;
            if (mem_ren) begin
                issued <= issued + 1'b1;
                if (mem_address != ADDR_LAST) begin
                    mem_address <= mem_address + 1'b1;
                end
            end
            if (inflight) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr    <= ~rd_ptr;
                pop_count <= pop_count + 1'b1;
            end
            case ({inflight, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Capture stage: read data lands one cycle after mem_ren; storage is not reset.
    always_ff @(posedge clk) begin
        if (inflight) begin
            fifo_mem[wr_ptr] <= mask_coef(mem_rdata);
        end
    end

endmodule

// File: tb/tb_polmem_reader.sv
// Bench for polmem_reader: PolMem model, randomized backpressure and an
// arithmetic reference for the expected word stream.
module tb_polmem_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [5:0]  mem_address;
    logic        mem_ren;
    logic [63:0] mem_rdata = '0;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [63:0] mem [64];
    int          passed = 0;
    int          total = 0;

    logic [63:0] beats[$];
    bit          lasts[$];
    int          ren_tot, pop_tot, ren_err, addr_err, stab_err, max_pend;
    int          first_valid, first_ren, last_beat_cyc, done_cyc;
    bit          timed_out, busy_at_done;

    polmem_reader dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_address(mem_address), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem[mem_address];
    end

    function automatic logic [63:0] model_word(input logic [63:0] w);
        logic [63:0] r = '0;
        for (int l = 0; l < 4; l++) begin
            logic [63:0] lane = (w >> (16 * l)) & 64'hFFFF;
            r = r | ((lane % 64'd8192) << (16 * l));
        end
        return r;
    endfunction

    function automatic int data_errs();
        int e = 0;
        for (int i = 0; i < beats.size(); i++)
            if (i >= 64 || beats[i] !== model_word(mem[i])) e++;
        if (beats.size() != 64) e++;
        return e;
    endfunction

    function automatic int last_errs();
        int e = 0;
        for (int i = 0; i < lasts.size(); i++)
            if (lasts[i] !== (i == 63)) e++;
        return e;
    endfunction

    function automatic logic pick(input int duty);
        return $urandom_range(0, 99) < duty;
    endfunction

    task automatic preload_random();
        for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
    endtask

    // Starts a read-out and observes it cycle by cycle until done, a planned reset, or timeout.
    task automatic run_stream(input int duty, input int stall_beat, input int start_beat, input int rst_beat);
        int          stall_left = 0;
        bit          stall_done = 0;
        bit          start_done = 0;
        logic        prev_stall = 0;
        logic [63:0] prev_data = '0;
        logic        prev_last = 0;
        logic        pop;
        logic        exp_ren;
        beats.delete();
        lasts.delete();
        ren_tot = 0; pop_tot = 0; ren_err = 0; addr_err = 0; stab_err = 0; max_pend = 0;
        first_valid = -1; first_ren = -1; last_beat_cyc = -1; done_cyc = -1;
        timed_out = 0; busy_at_done = 1;
        start = 1'b1;
        out_ready = pick(duty);
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 4000; c++) begin
            @(negedge clk);
            pop = out_valid && out_ready;
            if (mem_ren) begin
                if (!busy) ren_err++;
                if (int'(mem_address) != ren_tot) addr_err++;
                if (first_ren < 0) first_ren = c;
            end
            exp_ren = busy && (ren_tot < 64) && ((ren_tot - pop_tot - int'(pop)) < 2);
            if (mem_ren !== exp_ren) ren_err++;
            if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last)) stab_err++;
            if (out_valid && first_valid < 0) first_valid = c;
            if (pop) begin
                beats.push_back(out_data);
                lasts.push_back(out_last);
                last_beat_cyc = c;
                pop_tot++;
            end
            if (mem_ren) ren_tot++;
            if (ren_tot - pop_tot > max_pend) max_pend = ren_tot - pop_tot;
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (done) begin
                done_cyc = c;
                busy_at_done = busy;
                return;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (start_beat >= 0 && !start_done && pop_tot == start_beat) begin
                start = 1'b1;
                start_done = 1;
            end
            if (rst_beat >= 0 && pop_tot == rst_beat + 1) begin
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            if (stall_beat >= 0 && !stall_done && pop_tot == stall_beat) begin
                stall_left = 10;
                stall_done = 1;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = pick(duty);
            end
        end
        timed_out = 1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (mem_address !== 6'd0) $display("FAIL reset_addr got=%0d want=0", mem_address); else passed++;
        total++; if (mem_ren !== 1'b0) $display("FAIL reset_ren got=%b want=0", mem_ren); else passed++;
        total++; if (out_data !== 64'd0) $display("FAIL reset_data got=%h want=0", out_data); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", out_valid); else passed++;
        total++; if (out_last !== 1'b0) $display("FAIL reset_last got=%b want=0", out_last); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else passed++;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_full_stream();
        int e = 0;
        for (int i = 0; i < 64; i++) mem[i] = 64'(i) * 64'h0001000100010001;
        run_stream(100, -1, -1, -1);
        for (int i = 0; i < beats.size() && i < 64; i++)
            if (beats[i] !== 64'(i) * 64'h0001000100010001) e++;
        total++; if (timed_out) $display("FAIL full_timeout got=timeout want=done"); else passed++;
        total++; if (first_ren !== 1) $display("FAIL full_first_ren got=%0d want=1", first_ren); else passed++;
        total++; if (first_valid !== 3) $display("FAIL full_latency got=%0d want=3", first_valid); else passed++;
        total++; if (beats.size() !== 64) $display("FAIL full_count got=%0d want=64", beats.size()); else passed++;
        total++; if (e !== 0) $display("FAIL full_data got=%0d bad beats want=0", e); else passed++;
        total++; if (last_errs() !== 0) $display("FAIL full_last got=%0d bad flags want=0", last_errs()); else passed++;
        total++; if (last_beat_cyc !== first_valid + 63) $display("FAIL full_throughput got=%0d want=%0d", last_beat_cyc, first_valid + 63); else passed++;
        total++; if (done_cyc !== last_beat_cyc + 1) $display("FAIL full_done_cycle got=%0d want=%0d", done_cyc, last_beat_cyc + 1); else passed++;
        total++; if (busy_at_done !== 1'b0) $display("FAIL full_busy_at_done got=%b want=0", busy_at_done); else passed++;
        total++; if (ren_err !== 0 || addr_err !== 0) $display("FAIL full_issue got=%0d/%0d want=0/0", ren_err, addr_err); else passed++;
    endtask

    task automatic test_masking();
        preload_random();
        mem[5] = 64'hFFFF_FFFF_FFFF_FFFF;
        mem[6] = 64'hE000_2000_C001_1234;
        run_stream(100, -1, -1, -1);
        total++; if (beats.size() !== 64) $display("FAIL mask_count got=%0d want=64", beats.size()); else passed++;
        total++; if (beats[5] !== 64'h1FFF_1FFF_1FFF_1FFF) $display("FAIL mask_beat5 got=%h want=1fff1fff1fff1fff", beats[5]); else passed++;
        total++; if (beats[6] !== 64'h0000_0000_0001_1234) $display("FAIL mask_beat6 got=%h want=0000000000011234", beats[6]); else passed++;
        total++; if (data_errs() !== 0) $display("FAIL mask_random got=%0d bad beats want=0", data_errs()); else passed++;
    endtask

    task automatic test_backpressure();
        preload_random();
        run_stream(30, 17, -1, -1);
        total++; if (timed_out) $display("FAIL bp_timeout got=timeout want=done"); else passed++;
        total++; if (beats.size() !== 64) $display("FAIL bp_count got=%0d want=64", beats.size()); else passed++;
        total++; if (data_errs() !== 0) $display("FAIL bp_data got=%0d bad beats want=0", data_errs()); else passed++;
        total++; if (last_errs() !== 0) $display("FAIL bp_last got=%0d bad flags want=0", last_errs()); else passed++;
        total++; if (stab_err !== 0) $display("FAIL bp_stable got=%0d changes want=0", stab_err); else passed++;
        total++; if (ren_err !== 0) $display("FAIL bp_ren got=%0d bad cycles want=0", ren_err); else passed++;
        total++; if (addr_err !== 0) $display("FAIL bp_addr got=%0d bad cycles want=0", addr_err); else passed++;
        total++; if (max_pend > 2) $display("FAIL bp_pending got=%0d want<=2", max_pend); else passed++;
    endtask

    task automatic test_start_rules();
        int stray = 0;
        preload_random();
        run_stream(70, -1, 10, -1);
        total++; if (beats.size() !== 64) $display("FAIL start_busy_count got=%0d want=64", beats.size()); else passed++;
        total++; if (data_errs() !== 0) $display("FAIL start_busy_data got=%0d bad beats want=0", data_errs()); else passed++;
        total++; if (ren_err !== 0 || addr_err !== 0) $display("FAIL start_busy_issue got=%0d/%0d want=0/0", ren_err, addr_err); else passed++;
        repeat (5) begin
            @(negedge clk);
            if (done !== 1'b1 || mem_ren !== 1'b0 || out_valid !== 1'b0) stray++;
        end
        total++; if (stray !== 0) $display("FAIL done_hold got=%0d bad cycles want=0", stray); else passed++;
        preload_random();
        run_stream(100, -1, -1, -1);
        total++; if (first_valid !== 3) $display("FAIL restart_latency got=%0d want=3", first_valid); else passed++;
        total++; if (beats[0] !== model_word(mem[0])) $display("FAIL restart_beat0 got=%h want=%h", beats[0], model_word(mem[0])); else passed++;
        total++; if (data_errs() !== 0) $display("FAIL restart_data got=%0d bad beats want=0", data_errs()); else passed++;
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        preload_random();
        run_stream(100, -1, -1, 20);
        total++; if (beats.size() !== 21) $display("FAIL rstmid_reached got=%0d beats want=21", beats.size()); else passed++;
        @(negedge clk);
        total++; if ({out_valid, out_last, busy, done, mem_ren} !== 5'b0) $display("FAIL rstmid_ctrl got=%b want=00000", {out_valid, out_last, busy, done, mem_ren}); else passed++;
        total++; if (mem_address !== 6'd0 || out_data !== 64'd0) $display("FAIL rstmid_outputs got=%0d/%h want=0/0", mem_address, out_data); else passed++;
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || mem_ren !== 1'b0) stray++;
        end
        total++; if (stray !== 0) $display("FAIL rstmid_stale got=%0d bad cycles want=0", stray); else passed++;
        preload_random();
        run_stream(100, -1, -1, -1);
        total++; if (beats[0] !== model_word(mem[0])) $display("FAIL rstmid_beat0 got=%h want=%h", beats[0], model_word(mem[0])); else passed++;
        total++; if (data_errs() !== 0) $display("FAIL rstmid_data got=%0d bad beats want=0", data_errs()); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_full_stream();
        test_masking();
        test_backpressure();
        test_start_rules();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
